// File: rtl/vic_irq_ctrl_if.sv
// CPU-side bundle of the VIC interrupt block: raw sources, channel config, enable, ack in;
// request, vector and pending status out.
interface vic_irq_ctrl_if #(
  parameter int NUM_IRQ = 31,
  parameter int ADDR_W  = 5
);
  logic [NUM_IRQ-1:0]   i_ext;
  logic [4*NUM_IRQ-1:0] i_cfg;
  logic                 i_en;
  logic                 i_ack;
  logic                 o_irq;
  logic [ADDR_W-1:0]    o_irq_addr;
  logic [NUM_IRQ-1:0]   o_pending;

  modport slave (
    input  i_ext, i_cfg, i_en, i_ack,
    output o_irq, o_irq_addr, o_pending
  );

  modport master (
    output i_ext, i_cfg, i_en, i_ack,
    input  o_irq, o_irq_addr, o_pending
  );
endinterface

// File: rtl/vic_irq_ctrl.sv
// Vectored interrupt capture: synchronise sources, capture edge/level events, present the
// lowest pending index with an irq/ack handshake and a forced low cycle between vectors.
module vic_irq_ctrl #(
  parameter int NUM_IRQ     = 31,
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  vic_irq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] s_vec;
  logic [NUM_IRQ-1:0] en_v, fall_v, rise_v, pol_v;
  logic [NUM_IRQ-1:0] edge_mode, event_v, sel_oh, ack_clr;
  logic [ADDR_W-1:0]  addr_q, addr_d, enc_idx;
  logic               enc_vld, pend_sel;
  state_e             state_q, state_d;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= bus.i_ext;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q <= s_vec;
    end
  end

  assign s_vec = sync_q[SYNC_STAGES-1];

  // Config nibble per channel is {lvl_pol, rise, fall, en}.
  always_comb begin
    en_v   = '0;
    fall_v = '0;
    rise_v = '0;
    pol_v  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      en_v[i]   = bus.i_cfg[4*i];
      fall_v[i] = bus.i_cfg[4*i+1];
      rise_v[i] = bus.i_cfg[4*i+2];
      pol_v[i]  = bus.i_cfg[4*i+3];
    end
  end

  assign edge_mode = rise_v | fall_v;
  assign event_v   = (rise_v & s_vec & ~prev_q) | (fall_v & ~s_vec & prev_q);

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_IRQ; i++) sel_oh[i] = (addr_q == ADDR_W'(i));
  end

  assign pend_sel = |(pend_q & sel_oh);
  assign ack_clr  = (state_q == ST_REQ && bus.i_ack) ? sel_oh : '0;

  // A fresh event outranks the ack-clear so it is never lost; level channels ignore ack.
  assign pend_d = en_v & ((edge_mode & (event_v | (pend_q & ~ack_clr)))
                        | (~edge_mode & ~(s_vec ^ pol_v)));

  always_comb begin
    enc_idx = '0;
    enc_vld = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        enc_idx = ADDR_W'(i);
        enc_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_en && enc_vld) begin
          addr_d  = enc_idx;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.i_ack)                  state_d = ST_GAP;
        else if (!pend_sel || !bus.i_en) state_d = ST_IDLE;
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pend_q  <= '0;
      addr_q  <= '0;
      state_q <= ST_IDLE;
    end else begin
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      state_q <= state_d;
    end
  end

  assign bus.o_irq      = (state_q == ST_REQ);
  assign bus.o_irq_addr = addr_q;
  assign bus.o_pending  = pend_q;

endmodule

// File: tb/tb_vic_irq_ctrl.sv
// Bench for vic_irq_ctrl: directed scenarios with fixed expectations, then random traffic
// compared cycle by cycle against a rule-level reference model.
module tb_vic_irq_ctrl;
  localparam int N  = 31;
  localparam int AW = 5;
  localparam int SS = 2;

  localparam logic [3:0] C_EN   = 4'b0001;
  localparam logic [3:0] C_FALL = 4'b0010;
  localparam logic [3:0] C_RISE = 4'b0100;
  localparam logic [3:0] C_POL  = 4'b1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vic_irq_ctrl_if #(.NUM_IRQ(N), .ADDR_W(AW)) bus ();

  vic_irq_ctrl #(.NUM_IRQ(N), .ADDR_W(AW), .SYNC_STAGES(SS)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: synchroniser as a queue of samples, pending as a plain vector,
  // request side as "presenting / cooling down" flags.
  logic [N-1:0]  m_pipe[$];
  logic [N-1:0]  m_prev, m_pend;
  logic          m_req, m_gap;
  logic [AW-1:0] m_addr;

  task automatic model_reset();
    m_pipe.delete();
    for (int k = 0; k < SS; k++) m_pipe.push_back('0);
    m_prev = '0; m_pend = '0; m_req = 1'b0; m_gap = 1'b0; m_addr = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] s, nxt;
    logic [3:0]   c;
    logic         rose, fell, cleared;
    int           lo;
    s  = m_pipe[SS-1];
    lo = -1;
    for (int i = N - 1; i >= 0; i--) if (m_pend[i]) lo = i;
    for (int i = 0; i < N; i++) begin
      c       = bus.i_cfg[4*i +: 4];
      rose    = s[i] && !m_prev[i];
      fell    = !s[i] && m_prev[i];
      cleared = m_req && bus.i_ack && (int'(m_addr) == i);
      if (!c[0])             nxt[i] = 1'b0;
      else if (c[2] || c[1]) nxt[i] = (c[2] && rose) || (c[1] && fell) || (m_pend[i] && !cleared);
      else                   nxt[i] = (s[i] == c[3]);
    end
    if (m_req) begin
      if (bus.i_ack) begin m_req = 1'b0; m_gap = 1'b1; end
      else if (!m_pend[m_addr] || !bus.i_en) m_req = 1'b0;
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (bus.i_en && lo >= 0) begin
      m_req = 1'b1; m_addr = AW'(lo);
    end
    m_pend = nxt;
    m_prev = s;
    m_pipe.push_front(bus.i_ext);
    void'(m_pipe.pop_back());
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(int ch, logic [3:0] c);
    bus.i_cfg[4*ch +: 4] = c;
  endtask

  task automatic cfg_all(logic [3:0] c);
    for (int i = 0; i < N; i++) set_ch(i, c);
  endtask

  task automatic pulse_ack();
    bus.i_ack = 1'b1;
    tick();
    bus.i_ack = 1'b0;
  endtask

  function automatic logic [N-1:0] bit2(int a, int b);
    logic [N-1:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_ext = N'($urandom); bus.i_cfg = {4{31'($urandom)}}; bus.i_en = 1'b1; bus.i_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.o_irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", bus.o_irq); else passed++;
    checks++; if (bus.o_irq_addr !== '0) $display("FAIL reset_addr: got %0d want 0", bus.o_irq_addr); else passed++;
    checks++; if (bus.o_pending !== '0) $display("FAIL reset_pend: got %h want 0", bus.o_pending); else passed++;
    bus.i_ext = '0;
    cfg_all(C_RISE | C_EN);
    model_reset();
    rst_n = 1'b1;
    repeat (4) tick();
    checks++; if (bus.o_pending !== '0) $display("FAIL post_reset_pend: got %h want 0", bus.o_pending); else passed++;
  endtask

  task automatic test_edge_latency();
    bus.i_ext[5] = 1'b1;
    tick(); tick();
    checks++; if (bus.o_pending !== '0) $display("FAIL edge_pend_early: got %h want 0", bus.o_pending); else passed++;
    tick();
    checks++; if (bus.o_pending !== bit2(5, -1)) $display("FAIL edge_pend5: got %h want %h", bus.o_pending, bit2(5, -1)); else passed++;
    checks++; if (bus.o_irq !== 1'b0) $display("FAIL edge_irq_early: got %b want 0", bus.o_irq); else passed++;
    bus.i_ext[5] = 1'b0;
    tick();
    checks++; if (bus.o_irq !== 1'b1) $display("FAIL edge_irq: got %b want 1", bus.o_irq); else passed++;
    checks++; if (bus.o_irq_addr !== AW'(5)) $display("FAIL edge_addr: got %0d want 5", bus.o_irq_addr); else passed++;
    pulse_ack();
    checks++; if (bus.o_pending !== '0) $display("FAIL edge_ack_pend: got %h want 0", bus.o_pending); else passed++;
    checks++; if (bus.o_irq !== 1'b0) $display("FAIL edge_gap_irq: got %b want 0", bus.o_irq); else passed++;
    tick(); tick();
    checks++; if (bus.o_irq !== 1'b0) $display("FAIL edge_stay_low: got %b want 0", bus.o_irq); else passed++;
  endtask

  task automatic test_priority();
    bus.i_ext[9] = 1'b1; bus.i_ext[3] = 1'b1;
    repeat (3) tick();
    checks++; if (bus.o_pending !== bit2(3, 9)) $display("FAIL prio_pend: got %h want %h", bus.o_pending, bit2(3, 9)); else passed++;
    tick();
    checks++; if (bus.o_irq_addr !== AW'(3) || bus.o_irq !== 1'b1) $display("FAIL prio_first: got irq=%b addr=%0d want irq=1 addr=3", bus.o_irq, bus.o_irq_addr); else passed++;
    pulse_ack();
    checks++; if (bus.o_pending !== bit2(9, -1)) $display("FAIL prio_after_ack: got %h want %h", bus.o_pending, bit2(9, -1)); else passed++;
    tick(); tick();
    checks++; if (bus.o_irq_addr !== AW'(9) || bus.o_irq !== 1'b1) $display("FAIL prio_second: got irq=%b addr=%0d want irq=1 addr=9", bus.o_irq, bus.o_irq_addr); else passed++;
    pulse_ack();
    checks++; if (bus.o_pending !== '0) $display("FAIL prio_drained: got %h want 0", bus.o_pending); else passed++;
    bus.i_ext[9] = 1'b0; bus.i_ext[3] = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_level();
    set_ch(2, C_EN);
    tick();
    checks++; if (bus.o_pending !== bit2(2, -1)) $display("FAIL lvl_pend: got %h want %h", bus.o_pending, bit2(2, -1)); else passed++;
    tick();
    checks++; if (bus.o_irq !== 1'b1 || bus.o_irq_addr !== AW'(2)) $display("FAIL lvl_req: got irq=%b addr=%0d want irq=1 addr=2", bus.o_irq, bus.o_irq_addr); else passed++;
    pulse_ack();
    checks++; if (bus.o_pending !== bit2(2, -1) || bus.o_irq !== 1'b0) $display("FAIL lvl_ack: got irq=%b pend=%h want irq=0 pend=%h", bus.o_irq, bus.o_pending, bit2(2, -1)); else passed++;
    tick(); tick();
    checks++; if (bus.o_irq !== 1'b1 || bus.o_irq_addr !== AW'(2)) $display("FAIL lvl_rereq: got irq=%b addr=%0d want irq=1 addr=2", bus.o_irq, bus.o_irq_addr); else passed++;
    bus.i_ext[2] = 1'b1;
    repeat (3) tick();
    checks++; if (bus.o_pending !== '0 || bus.o_irq !== 1'b1) $display("FAIL lvl_drop: got irq=%b pend=%h want irq=1 pend=0", bus.o_irq, bus.o_pending); else passed++;
    tick();
    checks++; if (bus.o_irq !== 1'b0) $display("FAIL lvl_withdrawn: got %b want 0", bus.o_irq); else passed++;
    set_ch(2, C_RISE | C_EN);
    bus.i_ext[2] = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_collision();
    set_ch(7, C_FALL | C_EN);
    bus.i_ext[7] = 1'b1;
    repeat (4) tick();
    checks++; if (bus.o_pending !== '0) $display("FAIL fall_no_rise: got %h want 0", bus.o_pending); else passed++;
    bus.i_ext[7] = 1'b0;
    repeat (3) tick();
    checks++; if (bus.o_pending !== bit2(7, -1)) $display("FAIL fall_pend: got %h want %h", bus.o_pending, bit2(7, -1)); else passed++;
    tick();
    bus.i_ext[7] = 1'b1;
    tick();
    bus.i_ext[7] = 1'b0;
    tick(); tick();
    checks++; if (bus.o_irq !== 1'b1 || bus.o_irq_addr !== AW'(7)) $display("FAIL coll_req: got irq=%b addr=%0d want irq=1 addr=7", bus.o_irq, bus.o_irq_addr); else passed++;
    pulse_ack();
    checks++; if (bus.o_pending !== bit2(7, -1) || bus.o_irq !== 1'b0) $display("FAIL coll_set_wins: got irq=%b pend=%h want irq=0 pend=%h", bus.o_irq, bus.o_pending, bit2(7, -1)); else passed++;
    tick(); tick();
    checks++; if (bus.o_irq !== 1'b1 || bus.o_irq_addr !== AW'(7)) $display("FAIL coll_rereq: got irq=%b addr=%0d want irq=1 addr=7", bus.o_irq, bus.o_irq_addr); else passed++;
    pulse_ack();
    checks++; if (bus.o_pending !== '0) $display("FAIL coll_clear: got %h want 0", bus.o_pending); else passed++;
    set_ch(7, C_RISE | C_EN);
    repeat (3) tick();
  endtask

  task automatic test_gen_disable();
    bus.i_en = 1'b0;
    bus.i_ext[0] = 1'b1;
    repeat (4) tick();
    checks++; if (bus.o_pending !== bit2(0, -1) || bus.o_irq !== 1'b0) $display("FAIL gen_off: got irq=%b pend=%h want irq=0 pend=%h", bus.o_irq, bus.o_pending, bit2(0, -1)); else passed++;
    bus.i_en = 1'b1;
    tick();
    checks++; if (bus.o_irq !== 1'b1 || bus.o_irq_addr !== AW'(0)) $display("FAIL gen_on: got irq=%b addr=%0d want irq=1 addr=0", bus.o_irq, bus.o_irq_addr); else passed++;
    pulse_ack();
    bus.i_ext[0] = 1'b0;
    repeat (4) tick();
    checks++; if (bus.o_pending !== '0) $display("FAIL gen_clear: got %h want 0", bus.o_pending); else passed++;
  endtask

  task automatic test_async_reset();
    bus.i_ext[0] = 1'b1; bus.i_ext[4] = 1'b1;
    repeat (3) tick();
    checks++; if (bus.o_pending !== bit2(0, 4)) $display("FAIL ares_pend_before: got %h want %h", bus.o_pending, bit2(0, 4)); else passed++;
    tick();
    checks++; if (bus.o_irq !== 1'b1) $display("FAIL ares_req_before: got %b want 1", bus.o_irq); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.o_irq !== 1'b0) $display("FAIL ares_irq: got %b want 0", bus.o_irq); else passed++;
    checks++; if (bus.o_irq_addr !== '0) $display("FAIL ares_addr: got %0d want 0", bus.o_irq_addr); else passed++;
    checks++; if (bus.o_pending !== '0) $display("FAIL ares_pend: got %h want 0", bus.o_pending); else passed++;
    bus.i_ext = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) tick();
    checks++; if (bus.o_pending !== '0 || bus.o_irq !== 1'b0) $display("FAIL ares_discard: got irq=%b pend=%h want 0/0", bus.o_irq, bus.o_pending); else passed++;
  endtask

  task automatic test_random();
    logic [3:0] c;
    logic       last_ack;
    last_ack = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc % 100 == 0) begin
        for (int i = 0; i < N; i++) begin
          c = 4'($urandom);
          if ($urandom_range(0, 3) != 0) c[0] = 1'b1;
          set_ch(i, c);
        end
      end
      bus.i_en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N; i++) if ($urandom_range(0, 15) == 0) bus.i_ext[i] = ~bus.i_ext[i];
      bus.i_ack = !last_ack && ($urandom_range(0, 3) == 0);
      last_ack = bus.i_ack;
      tick();
      checks++; if (bus.o_pending !== m_pend) $display("FAIL rnd_pend @%0d: got %h want %h", cyc, bus.o_pending, m_pend); else passed++;
      checks++; if (bus.o_irq !== m_req) $display("FAIL rnd_irq @%0d: got %b want %b", cyc, bus.o_irq, m_req); else passed++;
      checks++; if (bus.o_irq_addr !== m_addr) $display("FAIL rnd_addr @%0d: got %0d want %0d", cyc, bus.o_irq_addr, m_addr); else passed++;
    end
    bus.i_ack = 1'b0;
  endtask

  initial begin
    bus.i_ext = '0; bus.i_cfg = '0; bus.i_en = 1'b0; bus.i_ack = 1'b0;
    model_reset();
    test_reset();
    bus.i_en = 1'b1;
    test_edge_latency();
    test_priority();
    test_level();
    test_collision();
    test_gen_disable();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vic_irq_ctrl.md
Name: vic_irq_ctrl

Overview:
Parametrised vectored interrupt capture and arbitration block for the VIC. Synchronises NUM_IRQ asynchronous external sources and detects per-channel configured edge or level events into a pending register. It presents the highest-priority pending channel to the CPU as a vector, with a request/acknowledge handshake. It sits between the external interrupt pins and the CPU interrupt input, and is configured from the VIC register file.

Parameters:
NUM_IRQ, 31, number of interrupt channels (1..64)
ADDR_W, 5, vector width; must satisfy 2**ADDR_W >= NUM_IRQ
SYNC_STAGES, 2, flip-flop stages in each input synchroniser (>=2)

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous, active-low reset
i_ext  input  NUM_IRQ  raw asynchronous interrupt sources
i_cfg  input  4*NUM_IRQ  per-channel config; channel i uses bits [4i+3:4i] = {lvl_pol, rise, fall, en}
i_en  input  1  global interrupt enable
i_ack  input  1  CPU acknowledge of the presented vector (single-cycle pulse)
o_irq  output  1  interrupt request to CPU
o_irq_addr  output  ADDR_W  index of the presented channel
o_pending  output  NUM_IRQ  pending register, for status readback

Behaviour:
- Reset (i_rst=0, asynchronous): synchronisers, previous-sample register, pending, FSM and outputs are all cleared. o_irq=0, o_irq_addr=0, o_pending=0. Deassertion takes effect at the next i_clk rising edge.
- Sync: each i_ext[i] passes through SYNC_STAGES flops, giving s[i]. p[i] is s[i] delayed by one cycle.
- Edge mode (rise|fall=1): the event is (rise & s & ~p) | (fall & ~s & p). When en=1, the event sets pending[i], which stays latched until cleared by ack.
- Level mode (rise=fall=0): pending[i] = en & (s[i]==lvl_pol), re-evaluated every cycle and never latched.
- en[i]=0: pending[i] is forced to 0 on the next cycle, in both modes.
- Latency: an edge on i_ext that is stable across a clock edge appears in o_pending SYNC_STAGES+1 cycles later. o_irq rises one cycle after that when the FSM is IDLE and i_en=1.
- Priority: a fixed encoder selects the lowest index with pending set.
- FSM states:
  - IDLE: o_irq=0. If i_en and any pending bit is set: latch the encoder index into o_irq_addr and go to REQ.
  - REQ: o_irq=1, and o_irq_addr stays stable even if a higher-priority channel becomes pending.
    - On i_ack=1: clear pending[o_irq_addr] if that channel is in edge mode, then go to GAP.
    - If pending[o_irq_addr] drops without ack (en cleared, or level deasserted) or i_en=0: go to IDLE with o_irq=0. This is a withdrawn request.
  - GAP: o_irq=0 for exactly one cycle, then IDLE. This guarantees a visible deassertion between vectors.
- A new edge event and the ack-clear on the same channel in the same cycle: the set wins, so the event is not lost and the channel re-requests after GAP.
- i_ack outside REQ is ignored.
- For a level channel, ack does not clear pending. If the level is still active after GAP, the channel requests again.
- i_en=0 gates only the request; edge events are still captured into pending.
- Reset asserted mid-operation (any state) returns to IDLE with everything cleared; captured events are discarded.
- o_irq_addr holds its last value in IDLE and GAP. Upper index bits beyond NUM_IRQ-1 are never produced.

Test Plan:
- Reset, then NUM_IRQ=31 with all channels edge-rise, en=1, i_en=1. Pulse i_ext[5] high for 3 cycles -> o_pending[5]=1 at cycle 3 after the sampled edge and o_irq=1 at cycle 4 with o_irq_addr=5. i_ack -> o_pending[5]=0, o_irq low for 1 cycle, then it stays low.
- Rising edges on channels 9 and 3 in the same cycle -> vector 3 first. After ack and GAP, vector 9. After the second ack, o_pending=0.
- Channel 2 in level mode with lvl_pol=0. Hold i_ext[2]=0 -> o_irq_addr=2 is presented. Ack with the input still 0 -> GAP, then re-request of 2. Set i_ext[2]=1 while in REQ -> o_irq drops with no ack (withdrawn).
- Channel 7 in fall mode. A falling edge lands in the same cycle as the ack-clear of channel 7 -> pending[7] stays 1 and channel 7 re-requests after GAP.
- i_en=0 with a rise edge on channel 0 -> o_pending[0]=1 and o_irq=0. Set i_en=1 -> o_irq=1 with vector 0 on the next cycle.
- Assert i_rst=0 asynchronously while in REQ with pending=0x00000011 -> o_irq, o_irq_addr and o_pending go to 0 immediately, without waiting for a clock edge.
